// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// The winner's request is latched in IDLE, the memory strobe is issued
// in ACCESS, and the requester is acknowledged in RESP. All outputs are registered.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrate and latch winner
// ACCESS | memory strobe active for one cycle; read data captured
// RESP   | ack (and err when out of range) to the winner for one cycle
module data_mem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic [AW-1:0] memAddr,
  output logic [31:0]   memWrData,
  output logic          memWrite,
  output logic          memRead,
  input  logic [31:0]   memRdData
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  // One extra bit so DEPTH itself is representable for any AW.
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  state_t state, state_nxt;

  logic          last_gnt, gnt, we_q, oor_q;
  logic          last_gnt_d, gnt_d, we_d, oor_d;
  logic [AW-1:0] mem_addr_d;
  logic [31:0]   mem_wr_data_d;
  logic          mem_write_d, mem_read_d;
  logic          ack0_d, ack1_d, err0_d, err1_d;
  logic [31:0]   rdata0_d, rdata1_d;

  logic          any_req, sel, sel_we, sel_oor;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  // Winner selection: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    any_req   = req0 | req1;
    sel       = (req0 && req1) ? ~last_gnt : req1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_oor   = ({1'b0, sel_addr} >= DEPTH_EXT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: ACCESS and RESP each last exactly one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched transaction.
  always_comb begin
    last_gnt_d    = last_gnt;
    gnt_d         = gnt;
    we_d          = we_q;
    oor_d         = oor_q;
    mem_addr_d    = memAddr;
    mem_wr_data_d = memWrData;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    err0_d        = 1'b0;
    err1_d        = 1'b0;
    rdata0_d      = rdata0;
    rdata1_d      = rdata1;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt_d         = sel;
          last_gnt_d    = sel;
          we_d          = sel_we;
          oor_d         = sel_oor;
          mem_addr_d    = sel_addr;
          mem_wr_data_d = sel_wdata;
          mem_write_d   = sel_we & ~sel_oor;
          mem_read_d    = ~sel_we & ~sel_oor;
        end
      end
      ACCESS: begin
        ack0_d = ~gnt;
        ack1_d = gnt;
        err0_d = ~gnt & oor_q;
        err1_d = gnt & oor_q;
        if (!we_q) begin
          if (gnt) rdata1_d = oor_q ? 32'h0 : memRdData;
          else     rdata0_d = oor_q ? 32'h0 : memRdData;
        end
      end
      RESP:    ;
      default: ;
    endcase
  end

  // Output and transaction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      memAddr   <= '0;
      memWrData <= '0;
      memWrite  <= 1'b0;
      memRead   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      last_gnt  <= last_gnt_d;
      gnt       <= gnt_d;
      we_q      <= we_d;
      oor_q     <= oor_d;
      memAddr   <= mem_addr_d;
      memWrData <= mem_wr_data_d;
      memWrite  <= mem_write_d;
      memRead   <= mem_read_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      err0      <= err0_d;
      err1      <= err1_d;
      rdata0    <= rdata0_d;
      rdata1    <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed cases followed by randomized traffic
// from both requesters, checked through a per-port expectation queue.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] memAddr, memWrData, memRdData;
  logic        memWrite, memRead;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] tb_mem[64];
  logic [31:0] ref_mem[64];
  logic        mem_init = 1'b0;
  logic        mon_en = 1'b0;

  logic [31:0] exp_rd0, exp_rd1;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;
  logic [31:0] prev_addr = '0, prev_wd = '0;

  data_mem_arbiter #(.DEPTH(64), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .memAddr(memAddr), .memWrData(memWrData),
    .memWrite(memWrite), .memRead(memRead), .memRdData(memRdData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'h0000_00AA : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Memory attached to the arbiter.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_val(i);
    end else if (memWrite && memAddr < 64) begin
      tb_mem[memAddr[5:0]] <= memWrData;
    end
  end
  assign memRdData = (memRead && memAddr < 64) ? tb_mem[memAddr[5:0]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ack(input bit p);
    exp_t e;
    if (p ? (q1.size() == 0) : (q0.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL ack_unexpected: port %0d acked with nothing outstanding at %0t", p, $time);
      return;
    end
    e = p ? q1.pop_front() : q0.pop_front();
    chk("err_win", p ? 32'(err1) : 32'(err0), 32'(e.err));
    chk("err_other", p ? 32'(err0) : 32'(err1), 0);
    chk("strobe_wr", 32'(prev_wr), 32'(e.we && !e.err));
    chk("strobe_rd", 32'(prev_rd), 32'(!e.we && !e.err));
    chk("addr_hold", memAddr, e.addr);
    if (!e.err) chk("strobe_addr", prev_addr, e.addr);
    if (e.we && !e.err) chk("strobe_wdata", prev_wd, e.wdata);
    if (!e.we) begin
      if (p) exp_rd1 = e.rdata;
      else   exp_rd0 = e.rdata;
    end
    chk("rdata0", rdata0, exp_rd0);
    chk("rdata1", rdata1, exp_rd1);
  endtask

  // Monitor: global invariants every cycle, scoreboard pop on each ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd0 = 32'h0;
      exp_rd1 = 32'h0;
    end
    chk("excl_strobe", 32'(memWrite & memRead), 0);
    chk("excl_ack", 32'(ack0 & ack1), 0);
    chk("wr_single", 32'(memWrite & prev_wr), 0);
    if (mon_en && rst_n) begin
      if (ack0) check_ack(1'b0);
      if (ack1) check_ack(1'b1);
    end
    prev_wr   = memWrite;
    prev_rd   = memRead;
    prev_addr = memAddr;
    prev_wd   = memWrData;
  end

  task automatic set_port(input bit p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack0"}, 32'(ack0), 0);
    chk({tag, "_ack1"}, 32'(ack1), 0);
    chk({tag, "_err0"}, 32'(err0), 0);
    chk({tag, "_err1"}, 32'(err1), 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_memaddr"}, memAddr, 0);
    chk({tag, "_memwrdata"}, memWrData, 0);
    chk({tag, "_memwrite"}, 32'(memWrite), 0);
    chk({tag, "_memread"}, 32'(memRead), 0);
  endtask

  // Directed single transaction; request dropped and inputs scrambled right after grant.
  task automatic txn(input bit p, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic oor;
    oor = (a >= 64);
    set_port(p, 1'b1, w, a, d);
    @(negedge clk);
    set_port(p, 1'b0, ~w, a + 4, ~d);
    chk("acc_read", 32'(memRead), 32'(!w && !oor));
    chk("acc_write", 32'(memWrite), 32'(w && !oor));
    chk("acc_addr", memAddr, a);
    if (w && !oor) chk("acc_wdata", memWrData, d);
    @(negedge clk);
    chk("resp_ack", p ? 32'(ack1) : 32'(ack0), 1);
    chk("resp_ack_other", p ? 32'(ack0) : 32'(ack1), 0);
    chk("resp_err", p ? 32'(err1) : 32'(err0), 32'(oor));
    chk("resp_addr", memAddr, a);
    chk("resp_strobes", 32'(memRead | memWrite), 0);
    @(negedge clk);
    chk("idle_ack", 32'(ack0 | ack1), 0);
  endtask

  // Random requester: port 0 owns words 0..31, port 1 owns 32..63, both hit out-of-range.
  task automatic drive(input bit p, input int n);
    for (int t = 0; t < n; t++) begin
      exp_t        e;
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      int          gap;
      bit          got;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'(64 + $urandom_range(0, 300));
      else a = 32'(p) * 32 + 32'($urandom_range(0, 31));
      e.we = w; e.addr = a; e.wdata = d; e.err = (a >= 64); e.rdata = 32'h0;
      if (!e.err) begin
        if (w) ref_mem[a[5:0]] = d;
        else   e.rdata = ref_mem[a[5:0]];
      end
      if (p) q1.push_back(e);
      else   q0.push_back(e);
      set_port(p, 1'b1, w, a, d);
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = p ? ack1 : ack0;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout: port %0d no ack within 40 cycles", p);
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        return;
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (gap) @(negedge clk);
      end
    end
    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Single read of word 5.
    txn(1'b0, 1'b0, 32'd5, 32'h0);
    chk("rd5_rdata0", rdata0, 32'h0000_00AA);
    chk("rd5_rdata1", rdata1, 32'h0);

    // Write then read on port 1.
    txn(1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF);
    txn(1'b1, 1'b0, 32'd10, 32'h0);
    chk("wr10_rdata1", rdata1, 32'hDEAD_BEEF);
    chk("wr10_rdata0_kept", rdata0, 32'h0000_00AA);

    // Out of range read.
    txn(1'b0, 1'b0, 32'd64, 32'h0);
    chk("oor_rdata0", rdata0, 32'h0);

    // Address changes from 3 to 7 after grant; transaction keeps 3.
    txn(1'b0, 1'b0, 32'd3, 32'h0);
    chk("addr3_rdata0", rdata0, init_val(3));

    // Contention from reset: grants alternate starting with port 0.
    rst_n = 1'b0;
    set_port(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'd2, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("cont_ack0", 32'(ack0), 32'(c % 6 == 1));
      chk("cont_ack1", 32'(ack1), 32'(c % 6 == 4));
    end
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset during the ACCESS cycle of a write.
    set_port(1'b0, 1'b1, 1'b1, 32'd20, 32'h0000_1234);
    @(negedge clk);
    chk("midop_write", 32'(memWrite), 1);
    rst_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_reset_vals("midop");
    rst_n = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'd40, 32'h0);
    repeat (2) @(negedge clk);
    chk("after_rst_ack0", 32'(ack0), 1);
    chk("after_rst_ack1", 32'(ack1), 0);
    chk("after_rst_rdata0", rdata0, init_val(1));
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Randomized traffic from both ports.
    rst_n = 1'b0;
    mem_init = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    mem_init = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    mon_en = 1'b1;
    fork
      drive(1'b0, 40);
      drive(1'b1, 40);
    join
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: DEPTH, default 64, number of 32-bit words in the shared data memory.
REQ-002 Parameter: AW, default 32, width of requester and memory address ports.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1, held until ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read, valid while reqN high.
REQ-007 addr0 / addr1  input  AW  word address, valid while reqN high.
REQ-008 wdata0 / wdata1  input  32  write data, valid while reqN high and weN=1.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to requester N.
REQ-010 err0 / err1  output  1  one-cycle pulse coincident with ackN when address was out of range.
REQ-011 rdata0 / rdata1  output  32  read result, registered, valid from ackN cycle until next ackN.
REQ-012 memAddr  output  AW  address to data memory.
REQ-013 memWrData  output  32  write data to data memory.
REQ-014 memWrite  output  1  memory write strobe.
REQ-015 memRead  output  1  memory read strobe.
REQ-016 memRdData  input  32  memory read data, combinational from memAddr while memRead=1.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP; all outputs registered.
REQ-018 IDLE: if no reqN, stay IDLE; else select winner, latch its we/addr/wdata, load memAddr/memWrData, go ACCESS.
REQ-019 Arbitration: single request wins; both requesting -> port not granted last (lastGnt register) wins; lastGnt updated on every grant.
REQ-020 ACCESS (exactly one cycle): in range -> memWrite=1 if write else memRead=1; rdataN of winner captured from memRdData at end of cycle on reads; go RESP.
REQ-021 Out-of-range (addr >= DEPTH): memWrite and memRead stay 0, rdataN loaded with 0 on reads, errN set for RESP.
REQ-022 RESP (exactly one cycle): ackN=1 (and errN if flagged) for winner only; memWrite=memRead=0; go IDLE.
REQ-023 Latency: req sampled high in IDLE at edge k -> strobe during cycle k+1 -> ack during cycle k+2; throughput one access per 3 cycles.
REQ-024 memAddr and memWrData SHALL be stable from the ACCESS cycle through the RESP cycle; memWrite never asserted for more than one cycle per grant.
REQ-025 memWrite and memRead SHALL never be 1 simultaneously.
REQ-026 Requester inputs SHALL be ignored outside IDLE; changes to addr/wdata/we after grant do not affect the transaction.
REQ-027 req dropped after grant: transaction still completes and ack issued.
REQ-028 req still high in cycle after ack: treated as new request in IDLE.
REQ-029 ack0 and ack1 SHALL never be 1 in the same cycle.
REQ-030 Write to a requester's own address followed by its read returns written data; rdata of the non-granted port is unchanged.

Reset
REQ-031 rst_n=0 at a rising edge: state=IDLE, lastGnt=1 (port 0 wins first tie), ack0/1=0, err0/1=0, rdata0/1=0, memAddr=0, memWrData=0, memWrite=0, memRead=0.
REQ-032 Reset in ACCESS or RESP aborts the transaction; no ack issued; memory strobes deasserted from the next cycle.

Verification
REQ-033 Single read: req0=1, we0=0, addr0=5, mem[5]=0x0000_00AA -> memRead high one cycle at k+1, ack0 at k+2, rdata0=0x0000_00AA, ack1=0.
REQ-034 Write then read: req1 write addr=10 data=0xDEAD_BEEF, then read addr=10 -> memWrite single-cycle pulse with memAddr=10, rdata1=0xDEAD_BEEF.
REQ-035 Contention: req0 and req1 held high from reset -> grants alternate 0,1,0,1, acks every 3 cycles, never overlapping.
REQ-036 Out of range: req0 read addr=64 (DEPTH=64) -> no memRead/memWrite, ack0 and err0 same cycle, rdata0=0.
REQ-037 Reset mid-op: rst_n=0 during ACCESS of a write -> no ack, all outputs at reset values next cycle, next req0 wins first.
REQ-038 Input change: addr0 changed from 3 to 7 in the ACCESS cycle -> memAddr stays 3 through RESP.
